// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver with arrow/WASD-style key decoding and a cursor
// position tracker. Frames are received on falling PS2Clock edges, decoded
// into held-key flags (Up/Down/Left/Right), and the cursor moves by STEP on
// each Tick, saturating at 0 and X_MAX/Y_MAX.
// Optional feature: define PS2_TIMEOUT_EN to abort frames that stall for
// TIMEOUT_CYCLES system clocks; otherwise the receiver waits indefinitely.
module ps2_key_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned STEP           = 1,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2Clock,
    input  logic       PS2Data,
    input  logic       Tick,
    output logic       Up,
    output logic       Down,
    output logic       Left,
    output logic       Right,
    output logic [7:0] ScanCode,
    output logic       CodeValid,
    output logic       FrameError,
    output logic [9:0] PosX,
    output logic [9:0] PosY
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    localparam logic [9:0] StepW = 10'(STEP);
    localparam logic [9:0] XMaxW = 10'(X_MAX);
    localparam logic [9:0] YMaxW = 10'(Y_MAX);
    localparam logic [9:0] XInit = 10'(X_MAX / 2);
    localparam logic [9:0] YInit = 10'(Y_MAX / 2);

    // Synchronizers plus one extra stage on the clock for edge detection
    logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic ps2d_s1_q, ps2d_s2_q;
    logic ps2_edge;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_ok_q, parity_ok_d;
    logic       good_byte, bad_frame;

    logic       brk_q, ext_q;
    logic [3:0] keys_q;   // {Right, Left, Down, Up}
    logic [3:0] map_sel;
    logic [7:0] scan_code_q;
    logic       code_valid_q, frame_error_q;
    logic [9:0] posx_q, posy_q;
    logic [9:0] x_dec, x_inc, y_dec, y_inc;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= PS2Clock;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= PS2Data;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign ps2_edge = ps2c_prev_q & ~ps2c_s2_q;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] to_cnt_q;
    logic           timeout_hit;

    // The TIMEOUT_CYCLES-th consecutive edge-free cycle of a frame aborts it
    assign timeout_hit = (state_q != StIdle) && !ps2_edge && (to_cnt_q == ToLast);

    // Stall counter: cleared on each PS/2 edge, in IDLE, and on abort
    always_ff @(posedge Clock) begin
        if (Reset || ps2_edge || state_q == StIdle || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    // Frame FSM next state; advances only on PS/2 falling edges
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        good_byte   = 1'b0;
        bad_frame   = 1'b0;
        if (ps2_edge) begin
            case (state_q)
                StIdle: begin
                    if (!ps2d_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    // Odd parity: total ones over data + parity must be odd
                    parity_ok_d = ^{shift_q, ps2d_s2_q};
                    state_d     = StStop;
                end
                default: begin
                    if (ps2d_s2_q && parity_ok_q) good_byte = 1'b1;
                    else                          bad_frame = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end else if (timeout_hit) begin
            state_d   = StIdle;
            bad_frame = 1'b1;
        end
    end

    // Frame FSM state registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
        end
    end

    // Key map lookup for the completed byte under the current extended prefix
    always_comb begin
        map_sel = 4'b0000;
        if (ext_q) begin
            case (shift_q)
                8'h75:   map_sel = 4'b0001;
                8'h72:   map_sel = 4'b0010;
                8'h6B:   map_sel = 4'b0100;
                8'h74:   map_sel = 4'b1000;
                default: map_sel = 4'b0000;
            endcase
        end else begin
            case (shift_q)
                8'h1D:   map_sel = 4'b0001;
                8'h1B:   map_sel = 4'b0010;
                8'h1C:   map_sel = 4'b0100;
                8'h23:   map_sel = 4'b1000;
                default: map_sel = 4'b0000;
            endcase
        end
    end

    // Byte decoder: output pulses, prefix tracking and held-key flags
    always_ff @(posedge Clock) begin
        if (Reset) begin
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            scan_code_q   <= 8'h00;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            keys_q        <= 4'b0000;
        end else begin
            code_valid_q  <= good_byte;
            frame_error_q <= bad_frame;
            if (good_byte) begin
                scan_code_q <= shift_q;
                if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else begin
                    keys_q <= (keys_q & ~map_sel) | (brk_q ? 4'b0000 : map_sel);
                    brk_q  <= 1'b0;
                    ext_q  <= 1'b0;
                end
            end else if (bad_frame) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end
        end
    end

    assign x_dec = (posx_q < StepW) ? 10'd0 : posx_q - StepW;
    assign x_inc = (posx_q > XMaxW - StepW) ? XMaxW : posx_q + StepW;
    assign y_dec = (posy_q < StepW) ? 10'd0 : posy_q - StepW;
    assign y_inc = (posy_q > YMaxW - StepW) ? YMaxW : posy_q + StepW;

    // Cursor movement on Tick, using key flags as they were before this edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            posx_q <= XInit;
            posy_q <= YInit;
        end else if (Tick) begin
            if (keys_q[0] ^ keys_q[1]) posy_q <= keys_q[0] ? y_dec : y_inc;
            if (keys_q[2] ^ keys_q[3]) posx_q <= keys_q[2] ? x_dec : x_inc;
        end
    end

    assign Up         = keys_q[0];
    assign Down       = keys_q[1];
    assign Left       = keys_q[2];
    assign Right      = keys_q[3];
    assign ScanCode   = scan_code_q;
    assign CodeValid  = code_valid_q;
    assign FrameError = frame_error_q;
    assign PosX       = posx_q;
    assign PosY       = posy_q;

endmodule
